// File: rtl/reg_file_wb.sv
// RV32I integer register file and writeback sink with a post-reset clear sequencer.
// Optional write-through bypass on the read ports is enabled by defining REG_FILE_WB_BYPASS_EN.
module reg_file_wb #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int IDX_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_w_op,
    input  logic [IDX_W-1:0] reg_w_reg_idx,
    input  logic [XLEN-1:0]  reg_w_reg_val,
    input  logic [IDX_W-1:0] reg_rs1,
    input  logic [IDX_W-1:0] reg_rs2,
    output logic [XLEN-1:0]  reg_rs1_val,
    output logic [XLEN-1:0]  reg_rs2_val,
    output logic             ready,
    output logic             w_drop
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    localparam logic [IDX_W-1:0] CLR_LAST = IDX_W'(REG_NUM - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
    localparam logic [XLEN-1:0]  VAL_ZERO = {XLEN{1'b0}};

    state_e           state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic             ready_q, ready_d;
    logic             w_drop_q, w_drop_d;

    logic [XLEN-1:0]  regs_q [REG_NUM];

    logic             wr_en_s;
    logic [IDX_W-1:0] wr_idx_s;
    logic [XLEN-1:0]  wr_val_s;
    logic             req_valid_s;

    assign req_valid_s = reg_w_op && (reg_w_reg_idx != IDX_ZERO);

    // Next-state, clear sequencing and array write-port selection.
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        w_drop_d  = w_drop_q;
        wr_en_s   = 1'b0;
        wr_idx_s  = IDX_ZERO;
        wr_val_s  = VAL_ZERO;
        if (rst) begin
            state_d   = ST_CLEAR;
            clr_idx_d = IDX_ZERO;
            ready_d   = 1'b0;
            w_drop_d  = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    wr_en_s  = 1'b1;
                    wr_idx_s = clr_idx_q;
                    wr_val_s = VAL_ZERO;
                    if (clr_idx_q == CLR_LAST) begin
                        state_d   = ST_READY;
                        ready_d   = 1'b1;
                        clr_idx_d = IDX_ZERO;
                    end else begin
                        clr_idx_d = clr_idx_q + IDX_W'(1);
                    end
                    // Execute writes cannot land while the array is being scrubbed.
                    if (req_valid_s) begin
                        w_drop_d = 1'b1;
                    end else begin
                        w_drop_d = w_drop_q;
                    end
                end
                ST_READY: begin
                    if (req_valid_s) begin
                        wr_en_s  = 1'b1;
                        wr_idx_s = reg_w_reg_idx;
                        wr_val_s = reg_w_reg_val;
                    end else begin
                        wr_en_s  = 1'b0;
                    end
                end
                default: begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = IDX_ZERO;
                    ready_d   = 1'b0;
                end
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_idx_q <= clr_idx_d;
        ready_q   <= ready_d;
        w_drop_q  <= w_drop_d;
    end

    // Register array; contents are only ever reset through the clear sequence.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            regs_q[wr_idx_s] <= wr_val_s;
        end
    end

    // Read ports: x0 and the whole file read as zero until the clear completes.
    always_comb begin
        reg_rs1_val = VAL_ZERO;
        reg_rs2_val = VAL_ZERO;
        if ((state_q == ST_READY) && (reg_rs1 != IDX_ZERO)) begin
            reg_rs1_val = regs_q[reg_rs1];
        end else begin
            reg_rs1_val = VAL_ZERO;
        end
        if ((state_q == ST_READY) && (reg_rs2 != IDX_ZERO)) begin
            reg_rs2_val = regs_q[reg_rs2];
        end else begin
            reg_rs2_val = VAL_ZERO;
        end
`ifdef REG_FILE_WB_BYPASS_EN
        if ((state_q == ST_READY) && req_valid_s && (reg_w_reg_idx == reg_rs1)) begin
            reg_rs1_val = reg_w_reg_val;
        end else begin
            reg_rs1_val = reg_rs1_val;
        end
        if ((state_q == ST_READY) && req_valid_s && (reg_w_reg_idx == reg_rs2)) begin
            reg_rs2_val = reg_w_reg_val;
        end else begin
            reg_rs2_val = reg_rs2_val;
        end
`endif
    end

    assign ready  = ready_q;
    assign w_drop = w_drop_q;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb: clear sequence, writes, x0, drops, resets, bypass.
module tb_reg_file_wb;

    logic        clk;
    logic        rst;
    logic        reg_w_op;
    logic [4:0]  reg_w_reg_idx;
    logic [31:0] reg_w_reg_val;
    logic [4:0]  reg_rs1;
    logic [4:0]  reg_rs2;
    logic [31:0] reg_rs1_val;
    logic [31:0] reg_rs2_val;
    logic        ready;
    logic        w_drop;

    int n_vec;
    int n_miscmp;

    reg_file_wb #(.XLEN(32), .REG_NUM(32), .IDX_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .reg_w_op      (reg_w_op),
        .reg_w_reg_idx (reg_w_reg_idx),
        .reg_w_reg_val (reg_w_reg_val),
        .reg_rs1       (reg_rs1),
        .reg_rs2       (reg_rs2),
        .reg_rs1_val   (reg_rs1_val),
        .reg_rs2_val   (reg_rs2_val),
        .ready         (ready),
        .w_drop        (w_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_idle();
        reg_w_op      = 1'b0;
        reg_w_reg_idx = 5'd0;
        reg_w_reg_val = 32'h0;
    endtask

    // Run the 32 clear edges, checking ready timing and zeroed reads throughout.
    task automatic run_clear(input logic exp_drop);
        for (int i = 1; i <= 32; i++) begin
            reg_rs1 = 5'(i);
            reg_rs2 = 5'(32 - i);
            #1;
            check_val("clr_rs1", reg_rs1_val, 32'h0);
            check_val("clr_rs2", reg_rs2_val, 32'h0);
            tick();
            check_val("clr_ready", {31'h0, ready}, (i == 32) ? 32'h1 : 32'h0);
        end
        check_val("clr_wdrop", {31'h0, w_drop}, {31'h0, exp_drop});
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            reg_rs1 = 5'(i);
            reg_rs2 = 5'(31 - i);
            #1;
            check_val(tag, reg_rs1_val, 32'h0);
        end
    endtask

    logic [31:0] byp_exp;

    initial begin
        n_vec    = 0;
        n_miscmp = 0;
        rst      = 1'b1;
        reg_rs1  = 5'd0;
        reg_rs2  = 5'd0;
        wr_idle();

        // Reset for two edges, then the clear sequence with drop stimulus.
        tick();
        tick();
        check_val("rst_ready", {31'h0, ready}, 32'h0);
        check_val("rst_wdrop", {31'h0, w_drop}, 32'h0);
        reg_rs1 = 5'd1;
        #1;
        check_val("rst_rs1", reg_rs1_val, 32'h0);
        rst = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            wr_idle();
            if (i == 2) begin
                reg_w_op = 1'b1; reg_w_reg_idx = 5'd0; reg_w_reg_val = 32'h11111111;
            end
            if (i == 3) begin
                reg_w_op = 1'b1; reg_w_reg_idx = 5'd7; reg_w_reg_val = 32'hFFFFFFFF;
            end
            reg_rs1 = 5'(i);
            #1;
            check_val("clr1_rs1", reg_rs1_val, 32'h0);
            tick();
            check_val("clr1_ready", {31'h0, ready}, (i == 32) ? 32'h1 : 32'h0);
            check_val("clr1_wdrop", {31'h0, w_drop}, (i >= 3) ? 32'h1 : 32'h0);
        end
        wr_idle();
        check_all_zero("post_clr_read");
        reg_rs1 = 5'd7;
        #1;
        check_val("x7_dropped", reg_rs1_val, 32'h0);

        // Basic write then read; x0 write ignored.
        reg_w_op = 1'b1; reg_w_reg_idx = 5'd5; reg_w_reg_val = 32'hDEADBEEF;
        reg_rs1 = 5'd5;
        tick();
        wr_idle();
        check_val("x5_read", reg_rs1_val, 32'hDEADBEEF);
        reg_w_op = 1'b1; reg_w_reg_idx = 5'd0; reg_w_reg_val = 32'h12345678;
        reg_rs2 = 5'd0;
        tick();
        wr_idle();
        check_val("x0_read", reg_rs2_val, 32'h0);
        check_val("wdrop_sticky", {31'h0, w_drop}, 32'h1);

        // Same-cycle read of the register being written.
`ifdef REG_FILE_WB_BYPASS_EN
        byp_exp = 32'hA5A5A5A5;
`else
        byp_exp = 32'h0;
`endif
        reg_w_op = 1'b1; reg_w_reg_idx = 5'd9; reg_w_reg_val = 32'hA5A5A5A5;
        reg_rs1 = 5'd9; reg_rs2 = 5'd9;
        #1;
        check_val("byp_rs1", reg_rs1_val, byp_exp);
        check_val("byp_rs2", reg_rs2_val, byp_exp);
        tick();
        wr_idle();
        check_val("x9_rs1", reg_rs1_val, 32'hA5A5A5A5);
        check_val("x9_rs2", reg_rs2_val, 32'hA5A5A5A5);

        // Reset with a concurrent write, restart mid-clear.
        rst = 1'b1;
        reg_w_op = 1'b1; reg_w_reg_idx = 5'd3; reg_w_reg_val = 32'h33333333;
        tick();
        wr_idle();
        rst = 1'b0;
        check_val("rst2_wdrop", {31'h0, w_drop}, 32'h0);
        check_val("rst2_ready", {31'h0, ready}, 32'h0);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midclr_ready", {31'h0, ready}, 32'h0);
        run_clear(1'b0);
        check_all_zero("post_mid_read");

        // Fill x1..x31 with their index, then reset from READY.
        for (int i = 1; i < 32; i++) begin
            reg_w_op = 1'b1; reg_w_reg_idx = 5'(i); reg_w_reg_val = 32'(i);
            tick();
        end
        wr_idle();
        for (int i = 1; i < 32; i++) begin
            reg_rs1 = 5'(i);
            reg_rs2 = 5'(32 - i);
            #1;
            check_val("fill_rs1", reg_rs1_val, 32'(i));
            check_val("fill_rs2", reg_rs2_val, 32'(32 - i));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rdy_rst_wdrop", {31'h0, w_drop}, 32'h0);
        check_val("rdy_rst_ready", {31'h0, ready}, 32'h0);
        run_clear(1'b0);
        check_all_zero("post_rdy_rst_read");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- Integer register file and writeback sink for the RV32I core.
- Sits directly downstream of the execute units. It consumes their write request bundle (reg_w_op / reg_w_reg_idx / reg_w_reg_val) and supplies rs1/rs2 operand values back to them.
- After reset, a sequencer clears every register before the file accepts writes, so the core never reads stale contents.

Parameters:
- XLEN, 32, register data width in bits.
- REG_NUM, 32, number of architectural registers; must be a power of two.
- IDX_W, 5, register index width; must equal log2(REG_NUM).

Ports:
- clk  input  1  core clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- reg_w_op  input  1  write request from execute; 1 = write this cycle.
- reg_w_reg_idx  input  IDX_W  destination register index.
- reg_w_reg_val  input  XLEN  value to write.
- reg_rs1  input  IDX_W  read port 1 index.
- reg_rs2  input  IDX_W  read port 2 index.
- reg_rs1_val  output  XLEN  read port 1 data (combinational).
- reg_rs2_val  output  XLEN  read port 2 data (combinational).
- ready  output  1  1 = clear complete and writes are accepted.
- w_drop  output  1  sticky flag: a write request arrived while ready = 0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. Everything below is sampled on the rising edge of clk.
- State machine has two states, CLEAR and READY. Counter clr_idx is IDX_W bits wide.
- Reset: rst = 1 at an edge forces state = CLEAR, clr_idx = 0, ready = 0, w_drop = 0. The register array is not reset directly.
- Reset mid-clear, or reset while in READY: the same effect; clearing restarts from index 0.
- CLEAR, each edge with rst = 0:
  - regs[clr_idx] <= 0 and clr_idx increments.
  - At the edge where clr_idx = REG_NUM-1: state <= READY, ready <= 1, clr_idx wraps to 0.
  - ready therefore rises after exactly REG_NUM edges with rst = 0.
- CLEAR, write requests:
  - A request with reg_w_op = 1 is discarded and sets w_drop <= 1.
  - Exception: index 0 is always ignored and never sets w_drop.
- READY, write: with reg_w_op = 1 and reg_w_reg_idx != 0, regs[idx] <= reg_w_reg_val at the edge, so the write is visible on the read ports in the next cycle.
- x0: writes to index 0 are ignored in every state. Reads of index 0 always return 0.
- Reads: reg_rsN_val = (idx == 0 || state == CLEAR) ? 0 : regs[idx]. Purely combinational, zero latency.
- Simultaneous events:
  - Both read ports may address the same register.
  - rst = 1 with reg_w_op = 1: reset wins, no write, w_drop stays 0.
- w_drop is cleared only by rst.
- Output reset values: ready = 0, w_drop = 0, reg_rs1_val = 0, reg_rs2_val = 0 (reads are forced to 0 in CLEAR).

Optional Feature:
- Macro: REG_FILE_WB_BYPASS_EN.
- Defined: write-through bypass. In READY, when reg_w_op = 1, reg_w_reg_idx != 0 and reg_w_reg_idx == reg_rsN, reg_rsN_val = reg_w_reg_val combinationally in the same cycle.
- Not defined: no bypass. A read in the write cycle returns the old contents; the new value appears the next cycle.
- The x0 rule and the CLEAR rule apply in both builds.

Test Plan:
- Clear sequence: rst high for 2 cycles then low. ready = 0 for 32 edges and rises after the 32nd. Reads of x1..x31 return 0 throughout and after.
- Basic write/read: in READY, write x5 = 0xDEADBEEF. Next cycle reg_rs1 = 5 gives 0xDEADBEEF. Write x0 = 0x12345678; reg_rs2 = 0 still gives 0.
- Write during clear: reg_w_op = 1, idx = 7, val = 0xFFFFFFFF at clear cycle 3. w_drop = 1 and stays 1. After ready, x7 reads 0. An index-0 write during clear leaves w_drop = 0.
- Reset mid-clear: assert rst at clear cycle 10. ready stays 0 and rises exactly 32 edges after the release.
- Bypass: write x9 = 0xA5A5A5A5 with reg_rs1 = reg_rs2 = 9 in the same cycle. With REG_FILE_WB_BYPASS_EN both ports read 0xA5A5A5A5 in that cycle; without it they read the old value (0), then 0xA5A5A5A5 the next cycle.
- Reset during READY: fill x1..x31 with their index values, pulse rst. w_drop = 0, ready = 0, all reads return 0 during clear and after ready returns.
